// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the instruction-memory read port, the branch-resolution inputs and
//   the decode-side valid/ready output of the fetch sequencer.
//
//   Signals
//     imem_addr   line index into instruction memory (sequencer -> memory)
//     imem_rdata  combinational read data for imem_addr (memory -> sequencer)
//     br_valid    one-cycle branch resolution strobe
//     br_taken    branch outcome, meaningful only with br_valid
//     br_target   taken-branch byte address
//     out_valid   out_instr/out_pc hold a fetched instruction
//     out_ready   decode accepts the presented instruction this cycle
//     out_instr   registered instruction word
//     out_pc      byte address of out_instr
//
//   Modports
//     master  the fetch sequencer side
//     slave   the environment side (memory, branch unit, decode)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int AW = 7
);
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          br_valid;
    logic          br_taken;
    logic [31:0]   br_target;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  br_valid,
        input  br_taken,
        input  br_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output br_valid,
        output br_taken,
        output br_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Single-slot instruction fetch stage. Walks the program counter through a
//   combinational instruction memory, presents one instruction at a time to
//   decode through a valid/ready handshake, follows taken-branch redirects with
//   a single bubble, and halts permanently (until rst) on an illegal fetch.
//
//   Ports
//     clk   in   single clock, all state updates on the rising edge
//     rst   in   synchronous active-high reset
//     bus   --   fetch_sequencer_if.master (imem port, branch inputs, decode output)
//     halt  out  sticky fetch-fault indicator
//
//   Parameters
//     RESET_PC    byte address of the first instruction
//     IMEM_DEPTH  instruction memory depth in words
//     AW          instruction memory line-index width
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          IMEM_DEPTH = 101,
    parameter int          AW         = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_sequencer_if.master     bus,
    output logic                  halt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_e;

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic        out_valid_q;
    logic        halt_q;

    logic [31:0] pc_d;
    logic [31:0] line_idx;
    logic        fetch_fault;
    logic        redirect;
    logic        slot_free;

    // Line index is computed in full 32-bit unsigned arithmetic so that the
    // range check sees wrap-around for pc < RESET_PC; the memory only gets
    // the low AW bits.
    assign line_idx    = (pc_q - RESET_PC) >> 2;
    assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (line_idx >= DEPTH_W);
    assign redirect    = bus.br_valid && bus.br_taken;
    // The output slot can take a new instruction when it is empty or when the
    // current one is being accepted on this very edge.
    assign slot_free   = !out_valid_q || bus.out_ready;
    assign pc_d        = pc_q + 32'd4;

    // NOTE: reset is sampled synchronously inside the clocked block, so it
    // only takes effect on a rising edge; all state uses non-blocking
    // assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halt_q      <= 1'b0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    // One idle cycle after reset; redirects are ignored here.
                    state_q <= RUN;
                end
                RUN, HOLD: begin
                    if (redirect) begin
                        // Redirect beats back-pressure: any held instruction is dropped.
                        pc_q        <= bus.br_target;
                        out_valid_q <= 1'b0;
                        state_q     <= RUN;
                    end else if (!slot_free) begin
                        state_q <= HOLD;
                    end else if (fetch_fault) begin
                        out_valid_q <= 1'b0;
                        halt_q      <= 1'b1;
                        state_q     <= HALT;
                    end else begin
                        out_instr_q <= bus.imem_rdata;
                        out_pc_q    <= pc_q;
                        out_valid_q <= 1'b1;
                        pc_q        <= pc_d;
                        state_q     <= RUN;
                    end
                end
                HALT: begin
                    // Terminal until rst.
                    state_q <= HALT;
                end
                default: state_q <= HALT;
            endcase
        end
    end

    assign bus.imem_addr = line_idx[AW-1:0];
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign halt          = halt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer: a table of cycle vectors, a few
//   hand-written multi-cycle sequences (end of memory, misaligned / low
//   targets, reset from HOLD and HALT), and a randomized phase compared each
//   cycle against a slot-and-stream reference model.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam int          IMEM_DEPTH = 101;
    localparam int          AW         = 7;

    logic clk;
    logic rst;
    logic halt;

    fetch_sequencer_if #(.AW(AW)) bus ();

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .IMEM_DEPTH(IMEM_DEPTH),
        .AW        (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master),
        .halt(halt)
    );

    logic [31:0] mem [0:(1<<AW)-1];
    assign bus.imem_rdata = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] pc);
        return (pc - RESET_PC) >> 2;
    endfunction

    function automatic logic bad_pc(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < RESET_PC) || (line_of(pc) >= 32'(IMEM_DEPTH));
    endfunction

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        return mem[int'(line_of(pc))];
    endfunction

    // Apply one cycle of inputs before the edge, return #1 after it.
    task automatic drive(input logic r, input logic rd, input logic bv, input logic bt,
                         input logic [31:0] tgt);
        @(negedge clk);
        rst           = r;
        bus.out_ready = rd;
        bus.br_valid  = bv;
        bus.br_taken  = bt;
        bus.br_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic ev, input logic [31:0] epc,
                              input logic eh);
        check({name, ".valid"}, 32'(bus.out_valid), 32'(ev));
        check({name, ".halt"}, 32'(halt), 32'(eh));
        if (ev) begin
            check({name, ".pc"}, bus.out_pc, epc);
            check({name, ".instr"}, bus.out_instr, instr_at(epc));
        end
    endtask

    // Two reset edges, then the BOOT cycle; leaves the DUT in RUN at RESET_PC.
    task automatic reset_dut();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("reset", 1'b0, 32'h0, 1'b0);
        check("reset.out_pc", bus.out_pc, 32'h0);
        check("reset.out_instr", bus.out_instr, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("boot", 1'b0, 32'h0, 1'b0);
        check("boot.addr", 32'(bus.imem_addr), 32'd0);
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        bv;
        logic        bt;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_halt;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rd, input logic bv, input logic bt,
                                input logic [31:0] tgt, input logic ev, input logic [31:0] epc,
                                input logic eh, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.ready = rd; v.bv = bv; v.bt = bt; v.tgt = tgt;
        v.e_valid = ev; v.e_pc = epc; v.e_halt = eh; v.e_addr = ea;
        return v;
    endfunction

    // Reference model: one output slot plus the address of the next instruction
    // in program order.
    logic        m_boot, m_halt, m_valid;
    logic [31:0] m_next, m_slot;

    task automatic model_step(input logic r, input logic rd, input logic bv, input logic bt,
                              input logic [31:0] tgt);
        if (r) begin
            m_boot = 1'b1; m_halt = 1'b0; m_valid = 1'b0; m_next = RESET_PC;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (bv && bt) begin
            m_valid = 1'b0; m_next = tgt;
        end else if (m_valid && !rd) begin
            m_valid = 1'b1;
        end else if (bad_pc(m_next)) begin
            m_halt = 1'b1; m_valid = 1'b0;
        end else begin
            m_slot = m_next; m_valid = 1'b1; m_next = m_next + 32'd4;
        end
    endtask

    vec_t tbl [19];

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'h0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

        // ---------------- table-driven vectors ----------------
        tbl[0]  = mk(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 32'h0,          1, 32'h0040_0000,  0, 1);
        tbl[3]  = mk(0, 1, 0, 0, 32'h0,          1, 32'h0040_0004,  0, 2);
        tbl[4]  = mk(0, 1, 0, 0, 32'h0,          1, 32'h0040_0008,  0, 3);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,          1, 32'h0040_0008,  0, 3);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,          1, 32'h0040_0008,  0, 3);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,          1, 32'h0040_0008,  0, 3);
        tbl[8]  = mk(0, 1, 0, 0, 32'h0,          1, 32'h0040_000C,  0, 4);
        tbl[9]  = mk(0, 1, 0, 0, 32'h0,          1, 32'h0040_0010,  0, 5);
        tbl[10] = mk(0, 1, 1, 1, 32'h0040_0040,  0, 32'h0,          0, 16);
        tbl[11] = mk(0, 1, 0, 0, 32'h0,          1, 32'h0040_0040,  0, 17);
        tbl[12] = mk(0, 1, 1, 0, 32'h0040_0100,  1, 32'h0040_0044,  0, 18);
        tbl[13] = mk(0, 0, 1, 1, 32'h0040_0080,  0, 32'h0,          0, 32);
        tbl[14] = mk(0, 1, 0, 0, 32'h0,          1, 32'h0040_0080,  0, 33);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,          1, 32'h0040_0080,  0, 33);
        tbl[16] = mk(0, 0, 1, 1, 32'h0040_0008,  0, 32'h0,          0, 2);
        tbl[17] = mk(0, 0, 0, 0, 32'h0,          1, 32'h0040_0008,  0, 3);
        tbl[18] = mk(0, 1, 0, 0, 32'h0,          1, 32'h0040_000C,  0, 4);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].ready, tbl[i].bv, tbl[i].bt, tbl[i].tgt);
            expect_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_halt);
            check($sformatf("vec%0d.addr", i), 32'(bus.imem_addr), tbl[i].e_addr);
        end

        // ---------------- run off the end of memory ----------------
        reset_dut();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0180);
        expect_out("end.bubble", 1'b0, 32'h0, 1'b0);
        check("end.addr", 32'(bus.imem_addr), 32'd96);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            expect_out($sformatf("end.seq%0d", k), 1'b1, 32'h0040_0180 + 32'(4 * k), 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("end.fault", 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, RESET_PC);
        expect_out("halt.redir_ignored", 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("halt.sticky", 1'b0, 32'h0, 1'b1);

        // ---------------- faulting redirect targets ----------------
        reset_dut();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0002);
        expect_out("misalign.bubble", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("misalign.fault", 1'b0, 32'h0, 1'b1);

        reset_dut();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h003F_FFFC);
        expect_out("low.bubble", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("low.fault", 1'b0, 32'h0, 1'b1);

        // ---------------- reset from HOLD and mid-redirect ----------------
        reset_dut();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("hold.first", 1'b1, 32'h0040_0000, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("hold.stable", 1'b1, 32'h0040_0000, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0040);
        expect_out("hold.rst", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("hold.boot", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("hold.restart", 1'b1, 32'h0040_0000, 1'b0);

        // ---------------- randomized against the model ----------------
        reset_dut();
        m_boot = 1'b0; m_halt = 1'b0; m_valid = 1'b0; m_next = RESET_PC; m_slot = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            logic        r, rd, bv, bt;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 9) < 7);
            bv  = ($urandom_range(0, 7) == 0);
            bt  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 19))
                0:       tgt = RESET_PC + 32'(4 * $urandom_range(0, 100)) + 32'd2;
                1:       tgt = RESET_PC - 32'(4 * $urandom_range(1, 8));
                2:       tgt = RESET_PC + 32'(4 * $urandom_range(101, 200));
                default: tgt = RESET_PC + 32'(4 * $urandom_range(0, 100));
            endcase
            model_step(r, rd, bv, bt, tgt);
            drive(r, rd, bv, bt, tgt);
            check("rand.valid", 32'(bus.out_valid), 32'(m_valid));
            check("rand.halt", 32'(halt), 32'(m_halt));
            if (m_valid) begin
                check("rand.pc", bus.out_pc, m_slot);
                check("rand.instr", bus.out_instr, instr_at(m_slot));
            end
            if (!bad_pc(m_next))
                check("rand.addr", 32'(bus.imem_addr), line_of(m_next));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
